// File: rtl/steg_pkg.sv
// steg_pkg: shared definitions for the LSB steganography embedder.
//   - state_e           : embedder FSM states
//   - PIX_W / MSG_W     : pixel and message byte widths
//   - LFSR_TAPS         : Galois feedback mask for the 16-bit keystream LFSR
//   - LFSR_DEFAULT_SEED : keystream seed used when none is supplied
//   - lfsr_next()       : one Galois step of the keystream LFSR
package steg_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned MSG_W = 8;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic {
        StIdle,
        StEmbed
    } state_e;

    // Right-shifting Galois step: the bit shifted out selects the tap mask.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lsb_embedder_if.sv
// lsb_embedder_if: the three valid/ready streams of the embedder.
//   msg_*  : plaintext message bytes into the embedder
//   pix_*  : cover pixels into the embedder
//   out_*  : stego pixels out of the embedder
// Modports:
//   master : stream source/sink side (drives msg/pix data, out_ready)
//   slave  : the embedder itself
interface lsb_embedder_if;
    import steg_pkg::*;

    logic             msg_valid;
    logic             msg_ready;
    logic [MSG_W-1:0] msg_data;

    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;

    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;

    modport master (
        output msg_valid, msg_data,
        output pix_valid, pix_data,
        output out_ready,
        input  msg_ready, pix_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  msg_valid, msg_data,
        input  pix_valid, pix_data,
        input  out_ready,
        output msg_ready, pix_ready,
        output out_valid, out_data
    );

endinterface

// File: rtl/steg_lfsr16.sv
// steg_lfsr16: 16-bit Galois LFSR producing the embedding keystream.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, loads SEED
//   load     : load load_val into the register (wins over step)
//   load_val : value to load
//   step     : advance one Galois step
//   state    : current register contents; state[0] is the keystream bit
module steg_lfsr16
    import steg_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/lsb_embedder.sv
// lsb_embedder: hides one message byte, LSB first, in the least significant
// bits of eight cover pixels. Each message bit is whitened with one bit of a
// continuously running LFSR keystream before it replaces the pixel LSB.
// Ports:
//   wb_clk    : clock, rising edge
//   wb_rst    : synchronous active-high reset
//   key_load  : load key into the keystream LFSR (honoured in IDLE only)
//   key       : keystream seed; zero selects LFSR_SEED
//   bus       : msg / pix / out valid-ready streams (slave side)
//   busy      : high while a byte is being embedded
//   byte_done : one-cycle pulse after the eighth bit of a byte is embedded
module lsb_embedder
    import steg_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          key_load,
    input  logic [15:0]   key,
    lsb_embedder_if.slave bus,
    output logic          busy,
    output logic          byte_done
);

    state_e           state_q;
    state_e           state_d;
    logic [2:0]       bit_cnt_q;
    logic [MSG_W-1:0] msg_sh_q;
    logic [PIX_W-1:0] out_data_q;
    logic             out_valid_q;
    logic             byte_done_q;

    logic             msg_rdy;
    logic             pix_rdy;
    logic             msg_fire;
    logic             pix_fire;
    logic             out_fire;
    logic             last_bit;

    logic             lfsr_load;
    logic [15:0]      lfsr_load_val;
    logic [15:0]      lfsr_state;

    // Pixel LSB is always overwritten.
    logic             unused_pix_lsb;
    assign unused_pix_lsb = bus.pix_data[0];

    always_comb begin
        msg_rdy  = 1'b0;
        pix_rdy  = 1'b0;
        state_d  = state_q;
        unique case (state_q)
            StIdle: begin
                msg_rdy = 1'b1;
            end
            StEmbed: begin
                // Accept a pixel whenever the output slot is empty or draining.
                pix_rdy = !out_valid_q || bus.out_ready;
            end
            default: ;
        endcase

        msg_fire = bus.msg_valid && msg_rdy;
        pix_fire = bus.pix_valid && pix_rdy;
        out_fire = out_valid_q && bus.out_ready;
        last_bit = pix_fire && (bit_cnt_q == 3'd7);

        if (msg_fire) begin
            state_d = StEmbed;
        end else if (last_bit) begin
            state_d = StIdle;
        end
    end

    // A key load only happens in IDLE, where no pixel can step the LFSR, so a
    // load coinciding with a message transfer seeds bit 0 of that byte.
    assign lfsr_load     = key_load && (state_q == StIdle);
    assign lfsr_load_val = (key == 16'h0000) ? LFSR_SEED : key;

    steg_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk      (wb_clk),
        .rst      (wb_rst),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .step     (pix_fire),
        .state    (lfsr_state)
    );

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            msg_sh_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_done_q <= last_bit;

            if (msg_fire) begin
                msg_sh_q  <= bus.msg_data;
                bit_cnt_q <= 3'd0;
            end else if (pix_fire) begin
                msg_sh_q  <= {1'b0, msg_sh_q[MSG_W-1:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            // A pixel transfer refills the slot even while it drains.
            if (pix_fire) begin
                out_data_q  <= {bus.pix_data[PIX_W-1:1], msg_sh_q[0] ^ lfsr_state[0]};
                out_valid_q <= 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.msg_ready = msg_rdy;
    assign bus.pix_ready = pix_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q == StEmbed);
    assign byte_done     = byte_done_q;

endmodule

// File: tb/tb_lsb_embedder.sv
// tb_lsb_embedder: self-checking bench for lsb_embedder.
// Directed byte vectors with hand-computed keystream bytes (the first eight
// keystream bits from a state equal that state's low byte), followed by
// stall, mid-byte reset and a randomized 64-byte plaintext-recovery run.
module tb_lsb_embedder;

    logic        wb_clk;
    logic        wb_rst;
    logic        key_load;
    logic [15:0] key;
    logic        busy;
    logic        byte_done;

    int n_cmp;
    int n_bad;

    lsb_embedder_if bus ();

    lsb_embedder #(
        .LFSR_SEED (16'hACE1)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .key_load  (key_load),
        .key       (key),
        .bus       (bus),
        .busy      (busy),
        .byte_done (byte_done)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    typedef struct {
        logic        do_key;
        logic        same_cycle;
        logic        mid_key;
        logic [15:0] key;
        logic [7:0]  msg;
        logic [7:0]  pix;
        logic [7:0]  ks;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [15:0] tb_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic do_reset();
        wb_rst        = 1'b1;
        key_load      = 1'b0;
        key           = 16'h0000;
        bus.msg_valid = 1'b0;
        bus.msg_data  = 8'h00;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'h00;
        bus.out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 16'(bus.out_valid), 16'd0);
        chk({tag, "_out_data"},  16'(bus.out_data),  16'h00);
        chk({tag, "_busy"},      16'(busy),          16'd0);
        chk({tag, "_byte_done"}, 16'(byte_done),     16'd0);
        chk({tag, "_msg_ready"}, 16'(bus.msg_ready), 16'd1);
        chk({tag, "_pix_ready"}, 16'(bus.pix_ready), 16'd0);
    endtask

    // One byte embedded back-to-back with out_ready held high.
    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] exp;
        if (v.do_key && !v.same_cycle) begin
            key_load = 1'b1;
            key      = v.key;
            tick();
            key_load = 1'b0;
        end
        bus.msg_valid = 1'b1;
        bus.msg_data  = v.msg;
        bus.out_ready = 1'b1;
        if (v.do_key && v.same_cycle) begin
            key_load = 1'b1;
            key      = v.key;
        end
        chk({tag, "_msg_ready_idle"}, 16'(bus.msg_ready), 16'd1);
        tick();
        bus.msg_valid = 1'b0;
        key_load      = 1'b0;
        chk({tag, "_busy_start"}, 16'(busy), 16'd1);
        chk({tag, "_msg_ready_embed"}, 16'(bus.msg_ready), 16'd0);
        bus.pix_valid = 1'b1;
        bus.pix_data  = v.pix;
        if (v.mid_key) begin
            key_load = 1'b1;
            key      = 16'hFFFF;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {v.pix[7:1], v.msg[i] ^ v.ks[i]};
            chk({tag, "_out_data"}, 16'(bus.out_data), 16'(exp));
            chk({tag, "_out_valid"}, 16'(bus.out_valid), 16'd1);
            chk({tag, "_byte_done"}, 16'(byte_done), 16'(i == 7));
            chk({tag, "_busy"}, 16'(busy), 16'(i != 7));
            if (i == 7) begin
                bus.pix_valid = 1'b0;
                key_load      = 1'b0;
                chk({tag, "_msg_ready_end"}, 16'(bus.msg_ready), 16'd1);
            end
        end
        tick();
        chk({tag, "_byte_done_once"}, 16'(byte_done), 16'd0);
        chk({tag, "_out_drained"}, 16'(bus.out_valid), 16'd0);
    endtask

    initial begin
        logic [7:0]  pixv[8];
        logic [7:0]  exp;
        logic [7:0]  smsg;
        logic [7:0]  sks;
        logic [7:0]  d;
        logic [7:0]  p;
        logic [7:0]  acc;
        logic [15:0] mlfsr;
        logic [7:0]  msgq[$];
        logic [7:0]  pixq[$];
        logic        msg_f;
        logic        pix_f;
        int          nbits;
        int          bytes_sent;
        int          bytes_got;

        n_cmp = 0;
        n_bad = 0;

        // {do_key, same_cycle, mid_key, key, msg, pix, keystream byte}
        vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'hFF, 8'hE1}; // ACE1 -> C2C4
        vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 8'hA5, 8'h00, 8'hC4}; // C2C4, EMBED key ignored
        vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h1234, 8'h3C, 8'h80, 8'h34};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0000, 8'h5A, 8'h55, 8'hE1}; // zero key -> seed
        vecs[4] = '{1'b1, 1'b1, 1'b0, 16'hBEEF, 8'hFF, 8'h11, 8'hEF}; // key with msg

        do_reset();
        chk_reset_outputs("reset");
        wb_rst = 1'b0;
        tick();
        chk_reset_outputs("post_reset");

        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v], $sformatf("vec%0d", v));
        end

        // Output back-pressure mid-byte.
        do_reset();
        wb_rst = 1'b0;
        smsg = 8'h0F;
        sks  = 8'hE1;
        for (int i = 0; i < 8; i++) pixv[i] = 8'(8'h13 + 8'(i * 37));
        bus.msg_valid = 1'b1;
        bus.msg_data  = smsg;
        tick();
        bus.msg_valid = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = pixv[0];
        bus.out_ready = 1'b0;
        tick();
        bus.pix_data = pixv[1];
        exp = {pixv[0][7:1], smsg[0] ^ sks[0]};
        chk("stall_first_out", 16'(bus.out_data), 16'(exp));
        chk("stall_pix_ready", 16'(bus.pix_ready), 16'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_hold_data", 16'(bus.out_data), 16'(exp));
            chk("stall_hold_valid", 16'(bus.out_valid), 16'd1);
            chk("stall_hold_pix_ready", 16'(bus.pix_ready), 16'd0);
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            bus.pix_data = pixv[i];
            tick();
            exp = {pixv[i][7:1], smsg[i] ^ sks[i]};
            chk("stall_out_data", 16'(bus.out_data), 16'(exp));
            chk("stall_byte_done", 16'(byte_done), 16'(i == 7));
        end
        bus.pix_valid = 1'b0;
        tick();
        chk("stall_drained", 16'(bus.out_valid), 16'd0);

        // Reset after three embedded bits abandons the byte.
        do_reset();
        wb_rst = 1'b0;
        bus.msg_valid = 1'b1;
        bus.msg_data  = 8'hFF;
        tick();
        bus.msg_valid = 1'b0;
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'hAA;
        for (int i = 0; i < 3; i++) tick();
        chk("midrst_busy_before", 16'(busy), 16'd1);
        wb_rst        = 1'b1;
        bus.pix_valid = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        wb_rst = 1'b0;
        tick();
        chk("midrst_no_done", 16'(byte_done), 16'd0);
        run_vec('{1'b0, 1'b0, 1'b0, 16'h0000, 8'hC3, 8'h42, 8'hE1}, "after_rst");

        // Random stream with stalls; recover plaintext from out_data[0].
        do_reset();
        wb_rst     = 1'b0;
        mlfsr      = 16'hACE1;
        nbits      = 0;
        acc        = 8'h00;
        bytes_sent = 0;
        bytes_got  = 0;
        for (int cyc = 0; cyc < 20000 && bytes_got < 64; cyc++) begin
            @(negedge wb_clk);
            if (bus.out_valid && bus.out_ready) begin
                d = bus.out_data;
                if (pixq.size() == 0) begin
                    chk("rand_unexpected_out", 16'(d), 16'hFFFF);
                end else begin
                    p = pixq.pop_front();
                    chk("rand_pix_upper", 16'(d[7:1]), 16'(p[7:1]));
                    acc[nbits] = d[0] ^ mlfsr[0];
                    mlfsr = tb_step(mlfsr);
                    nbits++;
                    if (nbits == 8) begin
                        chk("rand_byte", 16'(acc), 16'(msgq.pop_front()));
                        bytes_got++;
                        nbits = 0;
                    end
                end
            end
            msg_f = bus.msg_valid && bus.msg_ready;
            pix_f = bus.pix_valid && bus.pix_ready;
            if (msg_f) begin
                msgq.push_back(bus.msg_data);
                bytes_sent++;
            end
            if (pix_f) pixq.push_back(bus.pix_data);
            tick();
            if (msg_f) bus.msg_valid = 1'b0;
            if (pix_f) bus.pix_valid = 1'b0;
            if (!bus.msg_valid && bytes_sent < 64 && $urandom_range(0, 3) != 0) begin
                bus.msg_valid = 1'b1;
                bus.msg_data  = 8'($urandom);
            end
            if (!bus.pix_valid && $urandom_range(0, 3) != 0) begin
                bus.pix_valid = 1'b1;
                bus.pix_data  = 8'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        chk("rand_bytes_recovered", 16'(bytes_got), 16'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsb_embedder.md
LSB_EMBEDDER -- requirements
Module: lsb_embedder

Interface
REQ-001 Parameter: LFSR_SEED, default 16'hACE1, keystream seed used at reset and when a zero key is loaded.
REQ-002 wb_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 wb_rst  in  1  synchronous, active-high reset.
REQ-004 key_load  in  1  loads key into the LFSR (IDLE only).
REQ-005 key  in  16  keystream seed.
REQ-006 msg_valid / msg_ready  in / out  1 / 1  message-byte handshake.
REQ-007 msg_data  in  8  plaintext message byte.
REQ-008 pix_valid / pix_ready  in / out  1 / 1  cover-pixel handshake.
REQ-009 pix_data  in  8  cover pixel.
REQ-010 out_valid / out_ready  out / in  1 / 1  stego-pixel handshake.
REQ-011 out_data  out  8  stego pixel, registered.
REQ-012 busy  out  1  high in EMBED.
REQ-013 byte_done  out  1  one-cycle pulse when the 8th bit of a byte is embedded.

Function
REQ-014 Transfer on any channel occurs when valid and ready are both high in the same cycle.
REQ-015 The FSM has two states: IDLE and EMBED.
REQ-016 IDLE: msg_ready=1, pix_ready=0; a msg transfer loads msg_data into an 8-bit shift register, clears bit_cnt to 0 and enters EMBED.
REQ-017 EMBED: msg_ready=0; pix_ready = !out_valid || out_ready (combinational).
REQ-018 On each pix transfer: out_data <= {pix_data[7:1], msg_sh[0] ^ lfsr[0]}; out_valid <= 1; msg_sh shifts right (LSB first); LFSR advances one step; bit_cnt increments.
REQ-019 LFSR step is a 16-bit Galois shift: next = {1'b0, lfsr[15:1]} XOR (lfsr[0] ? 16'hB400 : 16'h0000).
REQ-020 A pix transfer with bit_cnt==7 returns to IDLE and pulses byte_done in the following cycle; bit_cnt wraps to 0.
REQ-021 out_valid clears on an out transfer that has no simultaneous pix transfer; a simultaneous out and pix transfer reloads out_data with no bubble (one pixel per cycle).
REQ-022 out_data and out_valid stay stable while out_valid=1 and out_ready=0.
REQ-023 Pending out_valid is unaffected by the EMBED->IDLE transition and drains normally in IDLE.
REQ-024 key_load in IDLE loads the LFSR with key, or with LFSR_SEED if key==0; key_load in EMBED is ignored.
REQ-025 If key_load and a msg transfer coincide in IDLE, the key load takes effect first, so byte bit 0 uses the new key's lfsr[0].
REQ-026 The LFSR is not reseeded between bytes; the keystream runs continuously across bytes.
REQ-027 Pixel-to-stego latency is 1 cycle.
REQ-028 The design has no combinational path from pix_data to out_data.

Reset
REQ-029 wb_rst forces: state=IDLE, out_valid=0, out_data=8'h00, byte_done=0, busy=0, bit_cnt=0, msg_sh=0, lfsr=LFSR_SEED.
REQ-030 Reset asserted mid-byte abandons the byte with no byte_done pulse and discards any pending output.

Structure
REQ-031 The shared package steg_pkg holds the state enum, LFSR_TAPS=16'hB400, default seed 16'hACE1 and the 8-bit pixel/message widths.
REQ-032 The block has one sub-module, steg_lfsr16, which provides load, step and a 16-bit state output.

Verification
REQ-033 After reset with seed ACE1: msg 0x00, then pixels 0xFF, 0xFF -> out 0xFF, then 0xFE (ks bits 1, 0; LFSR 0xACE1 -> 0xE270).
REQ-034 Eight pixels are sent back-to-back with out_ready=1 -> one output per cycle; byte_done pulses exactly once, 1 cycle after the 8th pixel; busy drops and msg_ready rises.
REQ-035 out_ready held low for 5 cycles mid-byte -> pix_ready=0 after the first output; out_data holds; no pixel is lost or duplicated.
REQ-036 key_load with key=0 -> LFSR=0xACE1; key_load=1 during EMBED -> LFSR sequence unchanged versus a reference model.
REQ-037 wb_rst asserted after 3 embedded bits -> all outputs at reset values the next cycle; a new byte then starts at bit 0 with LFSR=0xACE1.
REQ-038 A random stream of 64 bytes with random valid/ready stalls -> the scoreboard recovers the plaintext as out_data[0] XOR keystream for all bytes.
